// File: rtl/branch_feedback_tracker.sv
// In-order tracker for issued branch predictions: queues {pc, target, prediction}
// at fetch and emits one registered feedback beat per resolve, with mispredict and redirect.
package mips_core_pkg;
  typedef enum logic {
    NOT_TAKEN = 1'b0,
    TAKEN     = 1'b1
  } BranchOutcome;
endpackage

module branch_feedback_tracker
  import mips_core_pkg::*;
#(
  parameter int ADDR_WIDTH      = 32,
  parameter int DEPTH           = 4,
  parameter int FALLTHRU_OFFSET = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_pred_valid,
  input  logic [ADDR_WIDTH-1:0]        i_pred_pc,
  input  logic [ADDR_WIDTH-1:0]        i_pred_target,
  input  BranchOutcome                 i_pred_prediction,
  output logic                         o_pred_ready,
  input  logic                         i_res_valid,
  input  BranchOutcome                 i_res_outcome,
  input  logic                         i_flush,
  output logic                         o_fb_valid,
  output logic [ADDR_WIDTH-1:0]        o_fb_pc,
  output BranchOutcome                 o_fb_prediction,
  output BranchOutcome                 o_fb_outcome,
  output logic                         o_mispredict,
  output logic [ADDR_WIDTH-1:0]        o_redirect_pc,
  output logic [$clog2(DEPTH+1)-1:0]   o_count,
  output logic                         o_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  // Handshake: a prediction is taken on a clock edge where i_pred_valid && o_pred_ready;
  // o_pred_ready depends only on occupancy, so a same-cycle pop never frees a slot.
  // A resolve is taken on any edge with i_res_valid; it pops only if the queue is non-empty.

  logic [ADDR_WIDTH-1:0] pc_mem   [DEPTH];
  logic [ADDR_WIDTH-1:0] tgt_mem  [DEPTH];
  BranchOutcome          pred_mem [DEPTH];

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;

  logic                  empty;
  logic                  pop;
  logic                  push_acc;
  logic                  mispredict_now;
  logic [ADDR_WIDTH-1:0] head_pc;
  logic [ADDR_WIDTH-1:0] head_tgt;
  BranchOutcome          head_pred;
  logic [ADDR_WIDTH-1:0] redirect_now;

  always_comb begin
    empty          = (count == '0);
    o_pred_ready   = (count != CNT_W'(DEPTH));
    head_pc        = pc_mem[head];
    head_tgt       = tgt_mem[head];
    head_pred      = pred_mem[head];
    mispredict_now = (head_pred != i_res_outcome);
    pop            = i_res_valid && !empty && !i_flush;
    // A mispredicted resolve squashes everything younger, including this cycle's push.
    push_acc       = i_pred_valid && o_pred_ready && !i_flush && !(pop && mispredict_now);
    redirect_now   = (i_res_outcome == TAKEN) ? head_tgt
                                              : head_pc + ADDR_WIDTH'(FALLTHRU_OFFSET);
  end

  always_ff @(posedge clk) begin
    if (!rst && push_acc) begin
      pc_mem[tail]   <= i_pred_pc;
      tgt_mem[tail]  <= i_pred_target;
      pred_mem[tail] <= i_pred_prediction;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || i_flush || (pop && mispredict_now)) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push_acc) tail <= tail + 1'b1;
      if (pop)      head <= head + 1'b1;
      case ({push_acc, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Feedback is a single-cycle beat; all fields return to zero when idle.
  always_ff @(posedge clk) begin
    if (rst || !pop) begin
      o_fb_valid      <= 1'b0;
      o_fb_pc         <= '0;
      o_fb_prediction <= NOT_TAKEN;
      o_fb_outcome    <= NOT_TAKEN;
      o_mispredict    <= 1'b0;
      o_redirect_pc   <= '0;
    end else begin
      o_fb_valid      <= 1'b1;
      o_fb_pc         <= head_pc;
      o_fb_prediction <= head_pred;
      o_fb_outcome    <= i_res_outcome;
      o_mispredict    <= mispredict_now;
      o_redirect_pc   <= redirect_now;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      o_err <= 1'b0;
    end else if (i_res_valid && empty && !i_flush) begin
      o_err <= 1'b1;
    end
  end

  assign o_count = count;

endmodule

// File: tb/tb_branch_feedback_tracker.sv
// Bench for branch_feedback_tracker: directed vector table with hand-entered occupancy/err,
// a reference queue model feeding a feedback scoreboard, then a random traffic phase.
module tb_branch_feedback_tracker;
  import mips_core_pkg::*;

  localparam int AW    = 32;
  localparam int DEPTH = 4;
  localparam int FB_W  = AW + 1 + 1 + 1 + AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_pred_valid;
  logic [AW-1:0] i_pred_pc;
  logic [AW-1:0] i_pred_target;
  BranchOutcome  i_pred_prediction;
  logic          o_pred_ready;
  logic          i_res_valid;
  BranchOutcome  i_res_outcome;
  logic          i_flush;
  logic          o_fb_valid;
  logic [AW-1:0] o_fb_pc;
  BranchOutcome  o_fb_prediction;
  BranchOutcome  o_fb_outcome;
  logic          o_mispredict;
  logic [AW-1:0] o_redirect_pc;
  logic [2:0]    o_count;
  logic          o_err;

  branch_feedback_tracker #(.ADDR_WIDTH(AW), .DEPTH(DEPTH), .FALLTHRU_OFFSET(8)) dut (
    .clk(clk), .rst(rst),
    .i_pred_valid(i_pred_valid), .i_pred_pc(i_pred_pc), .i_pred_target(i_pred_target),
    .i_pred_prediction(i_pred_prediction), .o_pred_ready(o_pred_ready),
    .i_res_valid(i_res_valid), .i_res_outcome(i_res_outcome), .i_flush(i_flush),
    .o_fb_valid(o_fb_valid), .o_fb_pc(o_fb_pc), .o_fb_prediction(o_fb_prediction),
    .o_fb_outcome(o_fb_outcome), .o_mispredict(o_mispredict), .o_redirect_pc(o_redirect_pc),
    .o_count(o_count), .o_err(o_err)
  );

  // clock / reset
  always #5 clk = ~clk;

  typedef struct {
    logic          rst;
    logic          flush;
    logic          pv;
    logic [AW-1:0] pc;
    logic [AW-1:0] tgt;
    logic          pred;
    logic          rv;
    logic          outc;
    logic [2:0]    exp_count;
    logic          exp_ready;
    logic          exp_err;
  } vec_t;

  vec_t tbl[$];
  logic [FB_W-1:0] exp_q[$];

  // reference model state
  logic [AW-1:0] m_pc[$];
  logic [AW-1:0] m_tgt[$];
  logic          m_pred[$];
  logic          m_err;

  int n_vec  = 0;
  int n_cmp  = 0;
  int n_fail = 0;

  function automatic vec_t mk(logic r, logic f, logic pv, logic [AW-1:0] pc, logic [AW-1:0] tgt,
                              logic pred, logic rv, logic outc, logic [2:0] cnt, logic rdy,
                              logic err);
    vec_t v;
    v.rst = r; v.flush = f; v.pv = pv; v.pc = pc; v.tgt = tgt; v.pred = pred;
    v.rv = rv; v.outc = outc; v.exp_count = cnt; v.exp_ready = rdy; v.exp_err = err;
    return v;
  endfunction

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Model: queue semantics straight from the behaviour description.
  task automatic model_step(input vec_t v);
    logic          ready;
    logic          misp;
    logic [AW-1:0] pc, tgt, redir;
    logic          pred;
    misp = 1'b0;
    if (v.rst) begin
      m_pc.delete(); m_tgt.delete(); m_pred.delete(); m_err = 1'b0;
    end else if (v.flush) begin
      m_pc.delete(); m_tgt.delete(); m_pred.delete();
    end else begin
      ready = (m_pc.size() != DEPTH);
      if (v.rv) begin
        if (m_pc.size() > 0) begin
          pc = m_pc.pop_front(); tgt = m_tgt.pop_front(); pred = m_pred.pop_front();
          misp  = (pred != v.outc);
          redir = v.outc ? tgt : pc + 32'd8;
          exp_q.push_back({pc, pred, v.outc, misp, redir});
          if (misp) begin
            m_pc.delete(); m_tgt.delete(); m_pred.delete();
          end
        end else begin
          m_err = 1'b1;
        end
      end
      if (v.pv && ready && !misp) begin
        m_pc.push_back(v.pc); m_tgt.push_back(v.tgt); m_pred.push_back(v.pred);
      end
    end
  endtask

  // driver: apply one cycle, then check outputs #1 after the edge
  task automatic apply(input vec_t v, input bit use_tbl);
    logic [FB_W-1:0] e;
    rst               = v.rst;
    i_flush           = v.flush;
    i_pred_valid      = v.pv;
    i_pred_pc         = v.pc;
    i_pred_target     = v.tgt;
    i_pred_prediction = BranchOutcome'(v.pred);
    i_res_valid       = v.rv;
    i_res_outcome     = BranchOutcome'(v.outc);
    model_step(v);
    @(posedge clk);
    #1;
    n_vec++;
    if (o_fb_valid) begin
      if (exp_q.size() == 0) begin
        chk("fb_unexpected", 80'(o_fb_valid), 80'(0));
      end else begin
        e = exp_q.pop_front();
        chk("fb_beat", 80'({o_fb_pc, o_fb_prediction, o_fb_outcome, o_mispredict, o_redirect_pc}),
            80'(e));
      end
    end else if (exp_q.size() != 0) begin
      chk("fb_missing", 80'(o_fb_valid), 80'(1));
      exp_q.delete();
    end
    if (use_tbl) begin
      chk("count", 80'(o_count), 80'(v.exp_count));
      chk("ready", 80'(o_pred_ready), 80'(v.exp_ready));
      chk("err", 80'(o_err), 80'(v.exp_err));
    end else begin
      chk("count", 80'(o_count), 80'(m_pc.size()));
      chk("ready", 80'(o_pred_ready), 80'(m_pc.size() != DEPTH));
      chk("err", 80'(o_err), 80'(m_err));
    end
    if (v.rst) begin
      chk("rst_fb_pc", 80'(o_fb_pc), 80'(0));
      chk("rst_redirect", 80'(o_redirect_pc), 80'(0));
      chk("rst_fb_dirs", 80'({o_fb_valid, o_fb_prediction, o_fb_outcome, o_mispredict}), 80'(0));
    end
  endtask

  localparam logic T = 1'b1;
  localparam logic N = 1'b0;

  initial begin
    vec_t v;
    m_err = 1'b0;
    rst = 1'b1; i_flush = 1'b0; i_pred_valid = 1'b0; i_pred_pc = '0; i_pred_target = '0;
    i_pred_prediction = NOT_TAKEN; i_res_valid = 1'b0; i_res_outcome = NOT_TAKEN;

    //            rst f  pv pc            tgt          pred rv outc cnt rdy err
    tbl.push_back(mk(1, 0, 0, 0,            0,           N, 0, N, 0, 1, 0));
    tbl.push_back(mk(0, 0, 1, 32'h100,      32'h200,     T, 0, N, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0,            0,           N, 1, T, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0,            0,           N, 0, N, 0, 1, 0));
    // fill to full, overflow push dropped, drain in order across the wrap
    tbl.push_back(mk(0, 0, 1, 32'h10,       32'h1010,    T, 0, N, 1, 1, 0));
    tbl.push_back(mk(0, 0, 1, 32'h20,       32'h1020,    N, 0, N, 2, 1, 0));
    tbl.push_back(mk(0, 0, 1, 32'h30,       32'h1030,    T, 0, N, 3, 1, 0));
    tbl.push_back(mk(0, 0, 1, 32'h40,       32'h1040,    N, 0, N, 4, 0, 0));
    tbl.push_back(mk(0, 0, 1, 32'h50,       32'h1050,    T, 0, N, 4, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0,            0,           N, 1, T, 3, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0,            0,           N, 1, N, 2, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0,            0,           N, 1, T, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0,            0,           N, 1, N, 0, 1, 0));
    // push + correct pop in the same cycle
    tbl.push_back(mk(0, 0, 1, 32'h60,       32'h1060,    T, 0, N, 1, 1, 0));
    tbl.push_back(mk(0, 0, 1, 32'h70,       32'h1070,    N, 1, T, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0,            0,           N, 1, N, 0, 1, 0));
    // push while full refused even with a same-cycle pop
    tbl.push_back(mk(0, 0, 1, 32'h80,       32'h1080,    T, 0, N, 1, 1, 0));
    tbl.push_back(mk(0, 0, 1, 32'h90,       32'h1090,    T, 0, N, 2, 1, 0));
    tbl.push_back(mk(0, 0, 1, 32'ha0,       32'h10a0,    T, 0, N, 3, 1, 0));
    tbl.push_back(mk(0, 0, 1, 32'hb0,       32'h10b0,    T, 0, N, 4, 0, 0));
    tbl.push_back(mk(0, 0, 1, 32'hc0,       32'h10c0,    T, 1, T, 3, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0,            0,           N, 1, T, 2, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0,            0,           N, 1, T, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0,            0,           N, 1, T, 0, 1, 0));
    // predicted taken, resolved not taken: squash younger + same-cycle push, redirect 0x408
    tbl.push_back(mk(0, 0, 1, 32'h400,      32'h480,     T, 0, N, 1, 1, 0));
    tbl.push_back(mk(0, 0, 1, 32'h410,      32'h490,     N, 0, N, 2, 1, 0));
    tbl.push_back(mk(0, 0, 1, 32'h420,      32'h4a0,     T, 0, N, 3, 1, 0));
    tbl.push_back(mk(0, 0, 1, 32'h430,      32'h4b0,     T, 1, N, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0,            0,           N, 0, N, 0, 1, 0));
    // predicted not taken, resolved taken: redirect to target 0x900
    tbl.push_back(mk(0, 0, 1, 32'h800,      32'h900,     N, 0, N, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0,            0,           N, 1, T, 0, 1, 0));
    // resolve on empty queue: sticky err; same-cycle push accepted, not bypassed
    tbl.push_back(mk(0, 0, 0, 0,            0,           N, 1, T, 0, 1, 1));
    tbl.push_back(mk(0, 0, 1, 32'h500,      32'h580,     T, 1, T, 1, 1, 1));
    tbl.push_back(mk(0, 0, 0, 0,            0,           N, 1, T, 0, 1, 1));
    tbl.push_back(mk(0, 0, 0, 0,            0,           N, 0, N, 0, 1, 1));
    // flush beats same-cycle resolve and push; err survives
    tbl.push_back(mk(0, 0, 1, 32'h600,      32'h680,     T, 0, N, 1, 1, 1));
    tbl.push_back(mk(0, 0, 1, 32'h610,      32'h690,     T, 0, N, 2, 1, 1));
    tbl.push_back(mk(0, 0, 1, 32'h620,      32'h6a0,     T, 0, N, 3, 1, 1));
    tbl.push_back(mk(0, 1, 1, 32'h630,      32'h6b0,     T, 1, T, 0, 1, 1));
    // reset mid-stream
    tbl.push_back(mk(0, 0, 1, 32'h700,      32'h780,     T, 0, N, 1, 1, 1));
    tbl.push_back(mk(0, 0, 1, 32'h710,      32'h790,     T, 1, T, 1, 1, 1));
    tbl.push_back(mk(1, 0, 1, 32'h720,      32'h7a0,     T, 1, T, 0, 1, 0));
    // fall-through redirect wraps modulo 2^32
    tbl.push_back(mk(0, 0, 1, 32'hffff_fffc, 32'h10,     T, 0, N, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0,            0,           N, 1, N, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0,            0,           N, 0, N, 0, 1, 0));

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], 1'b1);

    // random traffic checked against the model
    for (int i = 0; i < 600; i++) begin
      v.rst   = ($urandom_range(0, 99) == 0);
      v.flush = ($urandom_range(0, 29) == 0);
      v.pv    = ($urandom_range(0, 1) == 1);
      v.pc    = ($urandom_range(0, 7) == 0) ? 32'hffff_fff8 : ($urandom() & ~32'h3);
      v.tgt   = $urandom() & ~32'h3;
      v.pred  = 1'($urandom_range(0, 1));
      v.rv    = ($urandom_range(0, 9) < 4);
      v.outc  = ($urandom_range(0, 3) == 0) ? ~v.pred : v.pred;
      v.exp_count = '0; v.exp_ready = 1'b0; v.exp_err = 1'b0;
      apply(v, 1'b0);
    end

    v = mk(0, 0, 0, 0, 0, N, 0, N, 0, 1, 0);
    apply(v, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
